// File: rtl/common_data_bus_pkg.sv
// Shared definitions for the common data bus: default widths, source codes,
// the broadcast record and the fixed-priority winner selection.
package cdb_pkg;

  localparam int TAG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_LSU  = 2'd3
  } src_e;

  // Broadcast record as seen by the reservation stations and the ROB.
  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] value;
  } cdb_bcast_t;

  // Branch beats ALU beats LSU.
  function automatic src_e pick_src(input logic br, input logic alu, input logic lsu);
    if (br)       return SRC_BR;
    else if (alu) return SRC_ALU;
    else if (lsu) return SRC_LSU;
    else          return SRC_NONE;
  endfunction

endpackage

// File: rtl/common_data_bus_if.sv
// Result/grant/broadcast signals between the execution units (master side)
// and the common data bus (slave side).
interface common_data_bus_if
  import cdb_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              branch_req;
  logic [TAG_W-1:0]  branch_tag;
  logic [DATA_W-1:0] branch_value;
  logic              alu_req;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W-1:0] alu_value;
  logic              lsu_req;
  logic [TAG_W-1:0]  lsu_tag;
  logic [DATA_W-1:0] lsu_value;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              branch_grant;
  logic              alu_grant;
  logic              lsu_grant;

  modport master (
    output branch_req, branch_tag, branch_value,
    output alu_req, alu_tag, alu_value,
    output lsu_req, lsu_tag, lsu_value,
    input  cdb_valid, cdb_tag, cdb_value,
    input  branch_grant, alu_grant, lsu_grant
  );

  modport slave (
    input  branch_req, branch_tag, branch_value,
    input  alu_req, alu_tag, alu_value,
    input  lsu_req, lsu_tag, lsu_value,
    output cdb_valid, cdb_tag, cdb_value,
    output branch_grant, alu_grant, lsu_grant
  );

endinterface

// File: rtl/common_data_bus_wait_counter.sv
// Saturating wait counter: clear has priority over increment, and the
// count sticks at all-ones instead of wrapping.
module wait_counter
  import cdb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/common_data_bus.sv
// Common data bus: combinational fixed-priority broadcast of one result per
// cycle, plus registered wait/winner/broadcast-count bookkeeping.
module common_data_bus
  import cdb_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  common_data_bus_if.slave bus,
  output logic [1:0]       last_src,
  output logic [CNT_W-1:0] branch_wait,
  output logic [CNT_W-1:0] alu_wait,
  output logic [CNT_W-1:0] lsu_wait,
  output logic [31:0]      bcast_count
);

  src_e              win_src;
  logic              valid;
  logic [TAG_W-1:0]  tag_sel;
  logic [DATA_W-1:0] value_sel;
  logic [2:0]        req_vec;
  logic [2:0]        grant_vec;
  logic [CNT_W-1:0]  wait_cnt [3];

  src_e              last_src_q;
  src_e              last_src_d;
  logic [31:0]       bcast_count_q;
  logic [31:0]       bcast_count_d;

  assign win_src = pick_src(bus.branch_req, bus.alu_req, bus.lsu_req);
  assign valid   = bus.branch_req | bus.alu_req | bus.lsu_req;

  // Idle bus drives zeros so downstream tag compares never see X.
  always_comb begin
    tag_sel   = '0;
    value_sel = '0;
    case (win_src)
      SRC_BR: begin
        tag_sel   = bus.branch_tag;
        value_sel = bus.branch_value;
      end
      SRC_ALU: begin
        tag_sel   = bus.alu_tag;
        value_sel = bus.alu_value;
      end
      SRC_LSU: begin
        tag_sel   = bus.lsu_tag;
        value_sel = bus.lsu_value;
      end
      default: begin
        tag_sel   = '0;
        value_sel = '0;
      end
    endcase
  end

  assign req_vec      = {bus.lsu_req, bus.alu_req, bus.branch_req};
  assign grant_vec[0] = (win_src == SRC_BR);
  assign grant_vec[1] = (win_src == SRC_ALU);
  assign grant_vec[2] = (win_src == SRC_LSU);

  assign bus.cdb_valid    = valid;
  assign bus.cdb_tag      = tag_sel;
  assign bus.cdb_value    = value_sel;
  assign bus.branch_grant = grant_vec[0];
  assign bus.alu_grant    = grant_vec[1];
  assign bus.lsu_grant    = grant_vec[2];

  // Index 0 = branch, 1 = ALU, 2 = LSU.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_wait
      wait_counter #(
        .CNT_W (CNT_W)
      ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (req_vec[gi] & ~grant_vec[gi]),
        .clr_i   (~req_vec[gi] | grant_vec[gi]),
        .count_o (wait_cnt[gi])
      );
    end
  endgenerate

  always_comb begin
    last_src_d    = last_src_q;
    bcast_count_d = bcast_count_q;
    if (valid) begin
      last_src_d    = win_src;
      bcast_count_d = bcast_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_src_q    <= SRC_NONE;
      bcast_count_q <= '0;
    end else begin
      last_src_q    <= last_src_d;
      bcast_count_q <= bcast_count_d;
    end
  end

  assign last_src    = last_src_q;
  assign branch_wait = wait_cnt[0];
  assign alu_wait    = wait_cnt[1];
  assign lsu_wait    = wait_cnt[2];
  assign bcast_count = bcast_count_q;

endmodule

// File: tb/tb_common_data_bus.sv
// Directed bench for common_data_bus: expected broadcast and bookkeeping
// values are queued as stimulus is applied and compared when sampled.
module tb_common_data_bus;

  logic        clk;
  logic        rst_n;
  logic [1:0]  last_src;
  logic [7:0]  branch_wait;
  logic [7:0]  alu_wait;
  logic [7:0]  lsu_wait;
  logic [31:0] bcast_count;

  int vectors;
  int miscompares;

  common_data_bus_if #(.TAG_W(5), .DATA_W(32)) bus ();

  common_data_bus #(.TAG_W(5), .DATA_W(32), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .last_src    (last_src),
    .branch_wait (branch_wait),
    .alu_wait    (alu_wait),
    .lsu_wait    (lsu_wait),
    .bcast_count (bcast_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  tag;
    logic [31:0] value;
    logic [2:0]  grants;
  } comb_exp_t;

  typedef struct {
    logic [7:0]  bw;
    logic [7:0]  aw;
    logic [7:0]  lw;
    logic [1:0]  last;
    logic [31:0] cnt;
  } st_exp_t;

  comb_exp_t comb_q[$];
  st_exp_t   st_q[$];

  // Reference bookkeeping state
  int          m_w[3];
  int          m_last;
  logic [31:0] m_cnt;
  int          step_no;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [4:0] bt, input logic [31:0] bv,
                       input logic ar, input logic [4:0] at, input logic [31:0] av,
                       input logic lr, input logic [4:0] lt, input logic [31:0] lv);
    comb_exp_t e;
    bus.branch_req = br; bus.branch_tag = bt; bus.branch_value = bv;
    bus.alu_req    = ar; bus.alu_tag    = at; bus.alu_value    = av;
    bus.lsu_req    = lr; bus.lsu_tag    = lt; bus.lsu_value    = lv;
    e.valid = br | ar | lr;
    if (br)      begin e.tag = bt;   e.value = bv;    e.grants = 3'b001; end
    else if (ar) begin e.tag = at;   e.value = av;    e.grants = 3'b010; end
    else if (lr) begin e.tag = lt;   e.value = lv;    e.grants = 3'b100; end
    else         begin e.tag = 5'd0; e.value = 32'd0; e.grants = 3'b000; end
    comb_q.push_back(e);
    #1;
    e = comb_q.pop_front();
    check("cdb_valid", {31'd0, bus.cdb_valid}, {31'd0, e.valid});
    check("cdb_tag", {27'd0, bus.cdb_tag}, {27'd0, e.tag});
    check("cdb_value", bus.cdb_value, e.value);
    check("grants", {29'd0, bus.lsu_grant, bus.alu_grant, bus.branch_grant}, {29'd0, e.grants});
    $display("bcast req=%b%b%b valid=%b tag=%0d value=0x%08h grants=%b%b%b",
             br, ar, lr, bus.cdb_valid, bus.cdb_tag, bus.cdb_value,
             bus.branch_grant, bus.alu_grant, bus.lsu_grant);
  endtask

  task automatic step();
    st_exp_t e;
    logic [2:0] req;
    logic [2:0] gnt;
    req = {bus.lsu_req, bus.alu_req, bus.branch_req};
    gnt = req[0] ? 3'b001 : (req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000));
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_w[i] = 0;
      m_last = 0;
      m_cnt  = 32'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || gnt[i]) m_w[i] = 0;
        else if (m_w[i] < 255) m_w[i] = m_w[i] + 1;
      end
      if (req != 3'b000) begin
        m_last = gnt[0] ? 1 : (gnt[1] ? 2 : 3);
        m_cnt  = m_cnt + 32'd1;
      end
    end
    e.bw = 8'(m_w[0]); e.aw = 8'(m_w[1]); e.lw = 8'(m_w[2]);
    e.last = 2'(m_last); e.cnt = m_cnt;
    st_q.push_back(e);
    @(posedge clk);
    #1;
    e = st_q.pop_front();
    step_no++;
    check("branch_wait", {24'd0, branch_wait}, {24'd0, e.bw});
    check("alu_wait", {24'd0, alu_wait}, {24'd0, e.aw});
    check("lsu_wait", {24'd0, lsu_wait}, {24'd0, e.lw});
    check("last_src", {30'd0, last_src}, {30'd0, e.last});
    check("bcast_count", bcast_count, e.cnt);
    $display("step %0d rst_n=%b waits=%0d/%0d/%0d last_src=%0d bcast_count=%0d",
             step_no, rst_n, branch_wait, alu_wait, lsu_wait, last_src, bcast_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    step_no     = 0;
    for (int i = 0; i < 3; i++) m_w[i] = 0;
    m_last = 0;
    m_cnt  = 32'd0;
    rst_n  = 1'b0;

    // Combinational arbitration while held in reset
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    drive(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 1, 5'd3, 32'h33333333);
    drive(0, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 1, 5'd3, 32'h33333333);
    drive(0, 5'd1, 32'h11111111, 0, 5'd2, 32'h22222222, 1, 5'd3, 32'h33333333);
    step();

    // All three requesting for three clocks
    rst_n = 1'b1;
    drive(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 1, 5'd3, 32'h33333333);
    for (int i = 0; i < 3; i++) step();
    check("plan_alu_wait_3", {24'd0, alu_wait}, 32'd3);
    check("plan_lsu_wait_3", {24'd0, lsu_wait}, 32'd3);
    check("plan_branch_wait_0", {24'd0, branch_wait}, 32'd0);
    check("plan_last_src_br", {30'd0, last_src}, 32'd1);
    check("plan_bcast_3", bcast_count, 32'd3);

    // LSU starved by branch long enough to saturate
    drive(1, 5'd7, 32'hA5A5A5A5, 0, 5'd2, 32'h22222222, 1, 5'd3, 32'h33333333);
    for (int i = 0; i < 300; i++) step();
    check("plan_lsu_sat", {24'd0, lsu_wait}, 32'd255);
    drive(1, 5'd7, 32'hA5A5A5A5, 0, 5'd2, 32'h22222222, 0, 5'd3, 32'h33333333);
    step();
    check("plan_lsu_drop", {24'd0, lsu_wait}, 32'd0);

    // Build nonzero ALU wait, then a one-edge reset mid-operation
    drive(1, 5'd4, 32'h0BADF00D, 1, 5'd5, 32'hCAFEBABE, 0, 5'd0, 32'd0);
    step();
    step();
    rst_n = 1'b0;
    drive(0, 5'd4, 32'h0BADF00D, 1, 5'd5, 32'hCAFEBABE, 1, 5'd6, 32'h12345678);
    step();
    check("plan_rst_bcast", bcast_count, 32'd0);
    check("plan_rst_last", {30'd0, last_src}, 32'd0);
    rst_n = 1'b1;

    // Tag 0 broadcast from the ALU alone, then LSU alone, then idle
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    step();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd31, 32'hFFFFFFFF);
    step();
    check("last_src_lsu", {30'd0, last_src}, 32'd3);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step();
    check("last_src_hold", {30'd0, last_src}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/common_data_bus.md
Name: common_data_bus

Overview:
- Common Data Bus (CDB) of the Tomasulo core. Three execution sources compete for one broadcast slot per cycle: branch unit, ALU and load/store unit (LSU).
- A fixed-priority arbiter picks one request and broadcasts its ROB/RS tag and result value to the reservation stations, ROB and register status.
- Arbitration and broadcast are combinational. Grant feedback lets losers hold their result.
- Clocked bookkeeping (per-source wait counters, last winner, broadcast count) is provided for stall and debug visibility.

Parameters:
- TAG_W, 5, width of tags.
- DATA_W, 32, width of broadcast values.
- CNT_W, 8, width of the per-source saturating wait counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- branch_req  in  1  branch unit has a result.
- branch_tag  in  TAG_W  branch result tag.
- branch_value  in  DATA_W  branch result value.
- alu_req  in  1  ALU has a result.
- alu_tag  in  TAG_W  ALU result tag.
- alu_value  in  DATA_W  ALU result value.
- lsu_req  in  1  LSU has a result.
- lsu_tag  in  TAG_W  LSU result tag.
- lsu_value  in  DATA_W  LSU result value.
- cdb_valid  out  1  a broadcast is present this cycle.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_value  out  DATA_W  broadcast value.
- branch_grant  out  1  branch result accepted this cycle.
- alu_grant  out  1  ALU result accepted this cycle.
- lsu_grant  out  1  LSU result accepted this cycle.
- last_src  out  2  registered winner of the previous valid broadcast: 0 none, 1 branch, 2 ALU, 3 LSU.
- branch_wait  out  CNT_W  consecutive cycles branch_req has been held without a grant.
- alu_wait  out  CNT_W  consecutive cycles alu_req has been held without a grant.
- lsu_wait  out  CNT_W  consecutive cycles lsu_req has been held without a grant.
- bcast_count  out  32  total broadcasts since reset.

Behaviour:
- Arbitration is purely combinational, with zero latency from inputs to cdb_* and *_grant. No dependency on clk or rst_n, so outputs are valid even before the first clock edge or during reset.
- Fixed priority: branch > ALU > LSU.
- cdb_valid = branch_req | alu_req | lsu_req.
- Winner's tag and value drive cdb_tag and cdb_value unmodified.
- No request: cdb_valid=0, cdb_tag=0, cdb_value=0. Outputs are never X.
- Exactly one grant is high when cdb_valid=1, and it belongs to the winner. All grants are 0 otherwise.
- A source that is not granted must hold req, tag and value stable until granted. The CDB does not buffer results.
- A req dropped without a grant is legal. Its wait counter clears.
- Tag values are opaque; tag 0 is broadcast like any other.
- Registered state updates on the rising edge of clk. When rst_n=0 on an edge, all counters clear, last_src=0 and bcast_count=0.
- Each wait counter, per source:
  - clears when req=0 or when the source is granted;
  - increments when req=1 and the source is not granted;
  - saturates at 2^CNT_W-1 with no wrap.
- last_src loads the winner code when cdb_valid=1 and holds otherwise.
- bcast_count increments by 1 per cycle with cdb_valid=1 and wraps modulo 2^32.
- Simultaneous requests from all three sources: only branch is granted. ALU and LSU wait counters both increment.

Decomposition:
- Shared package cdb_pkg: TAG_W/DATA_W defaults, source-code constants (SRC_NONE=0, SRC_BR=1, SRC_ALU=2, SRC_LSU=3), and a packed struct {valid, tag, value} for CDB broadcasts reused by the RS and ROB.
- One sub-module is natural: wait_counter, a saturating counter with inc/clr inputs, instantiated three times.
- The arbiter itself stays inline.

Test Plan:
- All req=0 (no clock needed) -> cdb_valid=0, tag=0, value=0, all grants 0.
- branch(1, 0x11111111), alu(2, 0x22222222) and lsu(3, 0x33333333) all requesting -> cdb_valid=1, tag=1, value=0x11111111, only branch_grant=1.
- Same inputs with branch_req=0 -> tag=2, value=0x22222222, alu_grant=1. Then alu_req=0 -> tag=3, value=0x33333333, lsu_grant=1.
- Reset, then hold all three reqs for 3 clocks -> alu_wait=lsu_wait=3, branch_wait=0, last_src=1, bcast_count=3.
- lsu_req held alone while a higher source requests for 300 cycles -> lsu_wait saturates at 255. Drop lsu_req -> 0 next edge.
- rst_n=0 for one edge mid-operation with counters nonzero -> all counters, last_src and bcast_count read 0 after the edge, while cdb_* still track the inputs combinationally.
